// File: rtl/warp_lsu.sv
// warp_lsu: serialising load/store unit for one warp memory instruction.
// An accepted instruction is walked lane by lane in ascending lane order.
// Each active lane issues one memory request, and a load keeps only one read
// outstanding at a time. Load data is gathered into per-lane buffers and
// written back to the register file in a single cycle.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   req_*             instruction offer (valid/ready) with per-lane address,
//                     store data and active-lane mask
//   mem_*             single-beat memory request channel (valid/ready)
//                     and read-data return (mem_rvalid/mem_rdata)
//   reg_write_*       register-file writeback, warp_num_write = issuing warp
//   done              one-cycle pulse when an instruction retires
//
// State table
//   state  | meaning
//   IDLE   | ready for a new instruction (req_ready=1)
//   REQ    | memory request for the pointed lane is on mem_*
//   WAIT   | load request accepted, waiting for mem_rvalid
//   WB     | one-cycle register-file writeback of the gathered load data
//   DONE   | retire pulse, then back to IDLE
module warp_lsu #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int LANES      = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_is_store,
   input  logic [1:0]                  req_warp,
   input  logic [3:0]                  req_rd,
   input  logic [LANES*DATA_WIDTH-1:0] req_addr,
   input  logic [LANES*DATA_WIDTH-1:0] req_wdata,
   input  logic [LANES-1:0]            req_mask,
   output logic                        mem_valid,
   input  logic                        mem_ready,
   output logic                        mem_we,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]       mem_wdata,
   input  logic                        mem_rvalid,
   input  logic [DATA_WIDTH-1:0]       mem_rdata,
   output logic                        reg_write_en,
   output logic [3:0]                  reg_write_addr,
   output logic [LANES*DATA_WIDTH-1:0] reg_write_data,
   output logic [1:0]                  warp_num_write,
   output logic                        done
);

   localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
   // Registers 13..15 are read-only; loads to them retire without writeback.
   localparam logic [3:0] RO_REG_FIRST = 4'd13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WB,
      S_DONE
   } state_t;

   state_t                      state_q, state_d;
   logic                        is_store_q, is_store_d;
   logic [1:0]                  warp_q, warp_d;
   logic [3:0]                  rd_q, rd_d;
   logic [LANES*ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LANES*DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [LANES*DATA_WIDTH-1:0] buf_q, buf_d;
   logic [LANES-1:0]            mask_q, mask_d;
   logic [LANES-1:0]            rem_q, rem_d;
   logic [PW-1:0]               ptr_q, ptr_d;
   logic [LANES-1:0]            rem_clr;

   // Only the low ADDR_WIDTH bits of each lane address are meaningful.
   logic req_addr_hi_unused;
   assign req_addr_hi_unused = ^req_addr;

   function automatic logic [PW-1:0] lowest_lane(input logic [LANES-1:0] m);
      lowest_lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (m[i]) lowest_lane = PW'(i);
      end
   endfunction

   // rem_q holds the lanes still to be serviced; the pointer is always its
   // lowest set bit, so retiring a lane is just clearing that bit.
   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      warp_d     = warp_q;
      rd_d       = rd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      mask_d     = mask_q;
      rem_d      = rem_q;
      ptr_d      = ptr_q;
      rem_clr    = rem_q & ~(LANES'(1) << ptr_q);

      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               is_store_d = req_is_store;
               warp_d     = req_warp;
               rd_d       = req_rd;
               wdata_d    = req_wdata;
               mask_d     = req_mask;
               rem_d      = req_mask;
               ptr_d      = lowest_lane(req_mask);
               buf_d      = '0;
               for (int i = 0; i < LANES; i++) begin
                  addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = req_addr[i*DATA_WIDTH +: ADDR_WIDTH];
               end
               state_d = (req_mask == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ready) begin
               if (is_store_q) begin
                  rem_d   = rem_clr;
                  ptr_d   = lowest_lane(rem_clr);
                  state_d = (rem_clr == '0) ? S_DONE : S_REQ;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               buf_d[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
               rem_d   = rem_clr;
               ptr_d   = lowest_lane(rem_clr);
               state_d = (rem_clr == '0) ? S_WB : S_REQ;
            end
         end
         S_WB:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         is_store_q <= 1'b0;
         warp_q     <= '0;
         rd_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         buf_q      <= '0;
         mask_q     <= '0;
         rem_q      <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         warp_q     <= warp_d;
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         buf_q      <= buf_d;
         mask_q     <= mask_d;
         rem_q      <= rem_d;
         ptr_q      <= ptr_d;
      end
   end

   // Outputs decode registered state only, so they never depend on inputs
   // in the same cycle.
   always_comb begin
      req_ready      = 1'b0;
      mem_valid      = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      reg_write_en   = 1'b0;
      reg_write_addr = '0;
      reg_write_data = '0;
      warp_num_write = '0;
      done           = 1'b0;

      unique case (state_q)
         S_IDLE: req_ready = 1'b1;
         S_REQ: begin
            mem_valid = 1'b1;
            mem_we    = is_store_q;
            mem_addr  = addr_q[int'(ptr_q)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata = wdata_q[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];
         end
         S_WB: begin
            reg_write_en   = (rd_q < RO_REG_FIRST);
            reg_write_addr = rd_q;
            warp_num_write = warp_q;
            for (int i = 0; i < LANES; i++) begin
               if (mask_q[i]) begin
                  reg_write_data[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[i*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_warp_lsu.sv
module tb_warp_lsu;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int L  = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_is_store = 1'b0;
   logic [1:0]    req_warp = '0;
   logic [3:0]    req_rd = '0;
   logic [L*DW-1:0] req_addr = '0;
   logic [L*DW-1:0] req_wdata = '0;
   logic [L-1:0]  req_mask = '0;
   logic          mem_valid;
   logic          mem_ready = 1'b1;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          reg_write_en;
   logic [3:0]    reg_write_addr;
   logic [L*DW-1:0] reg_write_data;
   logic [1:0]    warp_num_write;
   logic          done;

   warp_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(L)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_warp(req_warp), .req_rd(req_rd), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_mask(req_mask),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
      .reg_write_data(reg_write_data), .warp_num_write(warp_num_write),
      .done(done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } acc_t;
   typedef struct {
      int            c;
      logic [3:0]    a;
      logic [1:0]    w;
      logic [L*DW-1:0] d;
   } wb_t;

   acc_t acc_log[$];
   wb_t  wb_log[$];
   int   done_log[$];
   logic [DW-1:0] mem_model [256];

   // memory environment: 0 = always ready, 1 = random ready, 2 = held off
   int   ready_mode = 0;
   bit   spur_rv = 0;
   bit   rv_pend = 0;
   logic [DW-1:0] rv_data = '0;

   always @(posedge clk) begin
      #1;
      mem_rvalid = rv_pend || spur_rv;
      mem_rdata  = rv_pend ? rv_data : DW'($urandom);
      rv_pend    = 0;
      case (ready_mode)
         0:       mem_ready = 1'b1;
         1:       mem_ready = ($urandom_range(0, 2) != 0);
         default: mem_ready = 1'b0;
      endcase
   end

   bit            prev_stall = 0;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_wdata;
   logic          p_we;

   always @(negedge clk) begin
      if (prev_stall && !reset) begin
         vectors++;
         if (!(mem_valid === 1'b1 && mem_addr === p_addr && mem_we === p_we && mem_wdata === p_wdata)) begin
            miscompares++;
            $display("FAIL stall_hold: valid=%b we=%b addr=%h wdata=%h, expected valid=1 we=%b addr=%h wdata=%h",
                     mem_valid, mem_we, mem_addr, mem_wdata, p_we, p_addr, p_wdata);
         end
      end
      prev_stall = mem_valid && !mem_ready;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      p_we    = mem_we;
      if (mem_valid && mem_ready) begin
         acc_log.push_back('{mem_we, mem_addr, mem_wdata});
         if (!mem_we) begin
            rv_pend = 1;
            rv_data = mem_model[mem_addr];
         end
      end
      if (reg_write_en) wb_log.push_back('{cyc, reg_write_addr, warp_num_write, reg_write_data});
      if (done) done_log.push_back(cyc);
   end

   // One instruction end to end, checked against the lane-serial model.
   task automatic run_instr(input string name, input logic st, input logic [1:0] w,
                            input logic [3:0] rd, input logic [L-1:0] m,
                            input logic [L*DW-1:0] a, input logic [L*DW-1:0] wd,
                            input int stall_first, input int base_mode,
                            output int acc_c, output int done_c);
      acc_t exp_acc[$];
      logic [L*DW-1:0] exp_wd;
      bit   exp_wb;
      int   pop;
      int   exp_lat;
      logic [AW-1:0] s_addr;

      pop = 0;
      exp_wd = '0;
      for (int i = 0; i < L; i++) begin
         if (m[i]) begin
            pop++;
            exp_acc.push_back('{st, a[i*DW +: AW], st ? wd[i*DW +: DW] : '0});
            exp_wd[i*DW +: DW] = mem_model[a[i*DW +: AW]];
         end
      end
      exp_wb  = !st && (m != 0) && (rd < 13);
      exp_lat = (m == 0) ? 1 : (st ? pop + 1 : 2 * pop + 2);

      acc_log.delete();
      wb_log.delete();
      done_log.delete();
      ready_mode = (stall_first > 0) ? 2 : base_mode;

      @(posedge clk);
      #1;
      req_valid = 1'b1; req_is_store = st; req_warp = w; req_rd = rd;
      req_mask = m; req_addr = a; req_wdata = wd;
      acc_c = -1;
      for (int b = 0; b < 50 && acc_c < 0; b++) begin
         @(negedge clk);
         if (req_ready === 1'b1) acc_c = cyc;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr = {L*DW{1'b1}};
      req_wdata = {L*DW{1'b1}};
      req_mask = '1;

      vectors++;
      if (acc_c < 0) begin
         miscompares++;
         $display("FAIL %s accept: req_ready never seen, expected 1", name);
         done_c = -1;
         ready_mode = 0;
         return;
      end

      if (stall_first > 0) begin
         @(negedge clk);
         s_addr = mem_addr;
         vectors++;
         if (mem_valid !== 1'b1 || s_addr !== exp_acc[0].addr) begin
            miscompares++;
            $display("FAIL %s stall_start: valid=%b addr=%h, expected valid=1 addr=%h",
                     name, mem_valid, s_addr, exp_acc[0].addr);
         end
         for (int k = 1; k < stall_first; k++) begin
            @(negedge clk);
            vectors++;
            if (mem_valid !== 1'b1 || mem_addr !== s_addr) begin
               miscompares++;
               $display("FAIL %s stall_stable: valid=%b addr=%h, expected valid=1 addr=%h",
                        name, mem_valid, mem_addr, s_addr);
            end
         end
         ready_mode = base_mode;
      end

      done_c = -1;
      for (int b = 0; b < 400 && done_c < 0; b++) begin
         @(negedge clk);
         #1;
         if (done === 1'b1) done_c = cyc;
      end

      vectors++;
      if (done_c < 0) begin
         miscompares++;
         $display("FAIL %s done_timeout: done never pulsed, expected a pulse", name);
         return;
      end

      if (base_mode == 0) begin
         vectors++;
         if (done_c - acc_c != exp_lat + stall_first) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, done_c - acc_c, exp_lat + stall_first);
         end
      end

      vectors++;
      if (acc_log.size() != exp_acc.size()) begin
         miscompares++;
         $display("FAIL %s access_count: got %0d, expected %0d", name, acc_log.size(), exp_acc.size());
      end else begin
         for (int i = 0; i < exp_acc.size(); i++) begin
            vectors++;
            if (acc_log[i].we !== exp_acc[i].we || acc_log[i].addr !== exp_acc[i].addr ||
                (st && acc_log[i].data !== exp_acc[i].data)) begin
               miscompares++;
               $display("FAIL %s access[%0d]: we=%b addr=%h data=%h, expected we=%b addr=%h data=%h",
                        name, i, acc_log[i].we, acc_log[i].addr, acc_log[i].data,
                        exp_acc[i].we, exp_acc[i].addr, exp_acc[i].data);
            end
         end
      end

      vectors++;
      if (wb_log.size() != (exp_wb ? 1 : 0)) begin
         miscompares++;
         $display("FAIL %s wb_count: got %0d, expected %0d", name, wb_log.size(), exp_wb ? 1 : 0);
      end else if (exp_wb) begin
         vectors++;
         if (wb_log[0].a !== rd || wb_log[0].w !== w || wb_log[0].d !== exp_wd || wb_log[0].c != done_c - 1) begin
            miscompares++;
            $display("FAIL %s wb: rd=%0d warp=%0d cyc=%0d data=%h, expected rd=%0d warp=%0d cyc=%0d data=%h",
                     name, wb_log[0].a, wb_log[0].w, wb_log[0].c, wb_log[0].d, rd, w, done_c - 1, exp_wd);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: req_ready=%b, expected 1", req_ready);
      end
      vectors++;
      if ({mem_valid, mem_we, mem_addr, mem_wdata, reg_write_en, reg_write_addr,
           reg_write_data, warp_num_write, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: mem_valid=%b reg_write_en=%b done=%b addr=%h, expected all 0",
                  mem_valid, reg_write_en, done, mem_addr);
      end
   endtask

   task automatic test_store_full();
      logic [L*DW-1:0] a, wd;
      int ac, dc;
      for (int i = 0; i < L; i++) begin
         a[i*DW +: DW]  = DW'(i + 16);
         wd[i*DW +: DW] = DW'(i * 3);
      end
      run_instr("store_full", 1'b1, 2'd1, 4'd3, 8'hFF, a, wd, 0, 0, ac, dc);
   endtask

   task automatic test_load_sparse();
      logic [L*DW-1:0] a, wd;
      int ac, dc;
      for (int i = 0; i < L; i++) begin
         a[i*DW +: DW]  = DW'(8'h40 + i * 5);
         wd[i*DW +: DW] = DW'($urandom);
      end
      run_instr("load_sparse", 1'b0, 2'd2, 4'd4, 8'hA5, a, wd, 0, 0, ac, dc);
   endtask

   task automatic test_stall();
      logic [L*DW-1:0] a, wd;
      int ac, dc;
      for (int i = 0; i < L; i++) begin
         a[i*DW +: DW]  = DW'(8'hC0 + i);
         wd[i*DW +: DW] = '0;
      end
      run_instr("load_stall", 1'b0, 2'd3, 4'd7, 8'hFF, a, wd, 3, 0, ac, dc);
   endtask

   task automatic test_zero_mask();
      logic [L*DW-1:0] a;
      int ac, dc;
      a = {L*DW{1'b1}};
      run_instr("zero_mask_load", 1'b0, 2'd0, 4'd2, 8'h00, a, a, 0, 0, ac, dc);
      run_instr("zero_mask_store", 1'b1, 2'd1, 4'd2, 8'h00, a, a, 0, 0, ac, dc);
   endtask

   task automatic test_readonly_rd();
      logic [L*DW-1:0] a;
      int ac, dc;
      for (int i = 0; i < L; i++) a[i*DW +: DW] = DW'(i * 9);
      run_instr("readonly_rd14", 1'b0, 2'd1, 4'd14, 8'hFF, a, a, 0, 0, ac, dc);
   endtask

   task automatic test_back_to_back();
      logic [L*DW-1:0] a;
      int ac1, dc1, ac2, dc2;
      for (int i = 0; i < L; i++) a[i*DW +: DW] = DW'($urandom);
      run_instr("b2b_first", 1'b1, 2'd0, 4'd1, 8'h03, a, a, 0, 0, ac1, dc1);
      run_instr("b2b_second", 1'b0, 2'd1, 4'd5, 8'h81, a, a, 0, 0, ac2, dc2);
      vectors++;
      if (ac2 != dc1 + 1) begin
         miscompares++;
         $display("FAIL b2b_accept: second accepted at cycle %0d, expected %0d", ac2, dc1 + 1);
      end
   endtask

   task automatic test_reset_in_wait();
      bit bad_mv, bad_we, bad_done;
      ready_mode = 0;
      acc_log.delete();
      wb_log.delete();
      done_log.delete();
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_is_store = 1'b0; req_warp = 2'd1; req_rd = 4'd6;
      req_mask = 8'hFF;
      for (int i = 0; i < L; i++) req_addr[i*DW +: DW] = DW'(i + 1);
      @(negedge clk);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (!(mem_valid === 1'b1 && mem_ready === 1'b1)) begin
         miscompares++;
         $display("FAIL rst_wait_handshake: mem_valid=%b mem_ready=%b, expected 1 1", mem_valid, mem_ready);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      spur_rv = 1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_wait_idle: req_ready=%b mem_valid=%b, expected 1 0", req_ready, mem_valid);
      end
      bad_mv = 0; bad_we = 0; bad_done = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (mem_valid !== 1'b0) bad_mv = 1;
         if (reg_write_en !== 1'b0) bad_we = 1;
         if (done !== 1'b0) bad_done = 1;
      end
      spur_rv = 0;
      vectors++;
      if (bad_mv) begin
         miscompares++;
         $display("FAIL rst_wait_memvalid: mem_valid seen 1, expected 0");
      end
      vectors++;
      if (bad_we || wb_log.size() != 0) begin
         miscompares++;
         $display("FAIL rst_wait_wb: %0d writebacks, expected 0", wb_log.size());
      end
      vectors++;
      if (bad_done || done_log.size() != 0) begin
         miscompares++;
         $display("FAIL rst_wait_done: %0d done pulses, expected 0", done_log.size());
      end
   endtask

   task automatic test_random();
      logic [L*DW-1:0] a, wd;
      logic [L-1:0] m;
      int ac, dc;
      for (int j = 0; j < 256; j++) mem_model[j] = DW'($urandom);
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < L; i++) begin
            a[i*DW +: DW]  = DW'($urandom);
            wd[i*DW +: DW] = DW'($urandom);
         end
         m = ($urandom_range(0, 7) == 0) ? '0 : L'($urandom);
         run_instr("random", 1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), m, a, wd,
                   0, $urandom_range(0, 1), ac, dc);
      end
      ready_mode = 0;
   endtask

   initial begin
      for (int j = 0; j < 256; j++) mem_model[j] = DW'(j + 100);
      test_reset();
      test_store_full();
      test_load_sparse();
      test_stall();
      test_zero_mask();
      test_readonly_rd();
      test_back_to_back();
      test_reset_in_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
